// File: rtl/noc_port_requester_if.sv
// Bundles the flit input, arbiter handshake, forwarded flit and status signals of one requester port.
interface noc_port_requester_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_W     = 4
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_head;
    logic                  in_tail;
    logic                  in_ready;
    logic                  req;
    logic                  grant;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_head;
    logic                  out_tail;
    logic [WAIT_W-1:0]     wait_count;
    logic                  starved;
    logic                  proto_err;

    modport master (
        input  in_valid, in_data, in_head, in_tail, grant,
        output in_ready, req, out_valid, out_data, out_head, out_tail,
               wait_count, starved, proto_err
    );

    modport slave (
        output in_valid, in_data, in_head, in_tail, grant,
        input  in_ready, req, out_valid, out_data, out_head, out_tail,
               wait_count, starved, proto_err
    );
endinterface

// File: rtl/noc_port_requester.sv
// Requester-side NoC arbiter client: buffers flits, requests per packet, forwards one flit per grant
// and tracks grant wait time for starvation reporting.
module noc_port_requester #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WAIT_LIMIT = 3,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    noc_port_requester_if.master bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(WAIT_LIMIT);

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic {IDLE, PKT} state_t;

    flit_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state_q, state_d;
    flit_t             fifo_head;
    logic              empty, full, push, pop, fwd, drop, spurious, req_int;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic                  out_valid_q, out_head_q, out_tail_q, starved_q, proto_err_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign fifo_head = mem[rd_ptr];
    assign push      = bus.in_valid && !full;
    assign fwd       = req_int && bus.grant;
    assign pop       = fwd || drop;
    assign spurious  = bus.grant && !req_int;

    // Next state and request: a packet must start with a head flit; stray body flits are dropped in IDLE.
    always_comb begin
        state_d = state_q;
        req_int = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                req_int = !empty && fifo_head.head;
                drop    = !empty && !fifo_head.head;
                if (req_int && bus.grant && !fifo_head.tail) state_d = PKT;
            end
            PKT: begin
                req_int = !empty;
                if (req_int && bus.grant && fifo_head.tail) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait counter: an empty FIFO inside a packet is a bubble and freezes the count.
    always_comb begin
        wait_d = '0;
        if (req_int) begin
            if (bus.grant)              wait_d = '0;
            else if (wait_q == WAIT_MAX) wait_d = wait_q;
            else                        wait_d = wait_q + WAIT_W'(1);
        end else if (state_q == PKT && empty) begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{head: bus.in_head, tail: bus.in_tail, data: bus.in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Forwarded flit and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
            starved_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            out_valid_q <= fwd;
            if (fwd) begin
                out_data_q <= fifo_head.data;
                out_head_q <= fifo_head.head;
                out_tail_q <= fifo_head.tail;
            end
            starved_q   <= (wait_q > WAIT_LIM);
            proto_err_q <= drop || spurious;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.req        = req_int;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_head   = out_head_q;
    assign bus.out_tail   = out_tail_q;
    assign bus.wait_count = wait_q;
    assign bus.starved    = starved_q;
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_noc_port_requester.sv
// Scoreboard bench for noc_port_requester: expected flits queued at drive time, compared on out_valid.
module tb_noc_port_requester;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned WAIT_W     = 4;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic                  head;
        logic                  tail;
    } exp_t;

    logic clk;
    logic rst;
    logic tie;
    logic gnt;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    noc_port_requester_if #(.DATA_WIDTH(DATA_WIDTH), .WAIT_W(WAIT_W)) bus ();

    noc_port_requester #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(4),
        .WAIT_LIMIT(3),
        .WAIT_W(WAIT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb bus.grant = tie ? bus.req : gnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic t,
                         input logic [DATA_WIDTH-1:0] d, input logic expect_out);
        exp_t e;
        bus.in_valid = v;
        bus.in_head  = h;
        bus.in_tail  = t;
        bus.in_data  = d;
        if (v && expect_out) begin
            e.data = d;
            e.head = h;
            e.tail = t;
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: every forwarded flit must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 64'(bus.out_valid), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.data));
                check("out_head", 64'(bus.out_head), 64'(e.head));
                check("out_tail", 64'(bus.out_tail), 64'(e.tail));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        tie = 1'b0;
        gnt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        next();
        next();
        check("rst_req",       64'(bus.req),        64'(0));
        check("rst_out_valid", 64'(bus.out_valid),  64'(0));
        check("rst_out_data",  64'(bus.out_data),   64'(0));
        check("rst_wait",      64'(bus.wait_count), 64'(0));
        check("rst_starved",   64'(bus.starved),    64'(0));
        check("rst_proto_err", 64'(bus.proto_err),  64'(0));
        #2 rst = 1'b0;

        // Single-flit packet with grant tied to req.
        next();
        tie = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hA5, 1'b1);
        check("sf_in_ready0", 64'(bus.in_ready), 64'(1));
        check("sf_req0",      64'(bus.req),      64'(0));
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("sf_req1",      64'(bus.req),      64'(1));
        check("sf_in_ready1", 64'(bus.in_ready), 64'(1));
        next();
        check("sf_out_valid", 64'(bus.out_valid), 64'(1));
        check("sf_out_data",  64'(bus.out_data),  64'(32'hA5));
        check("sf_req2",      64'(bus.req),       64'(0));
        check("sf_in_ready2", 64'(bus.in_ready),  64'(1));

        // Fill to full without grant, then drain back-to-back.
        tie = 1'b0;
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i == 0), 1'(i == 3), DATA_WIDTH'(i + 1), 1'b1);
            check("fill_in_ready", 64'(bus.in_ready), 64'(1));
            next();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h5, 1'b0);
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("full_ignored", 64'(bus.in_ready), 64'(0));
        check("full_req",     64'(bus.req),      64'(1));
        for (int i = 0; i < 4; i++) begin
            gnt = 1'b1;
            next();
            gnt = 1'b0;
            check("drain_valid", 64'(bus.out_valid), 64'(1));
            check("drain_data",  64'(bus.out_data),  64'(i + 1));
        end
        check("drain_req_after_tail", 64'(bus.req),      64'(0));
        check("drain_in_ready",       64'(bus.in_ready), 64'(1));
        next();
        check("drain_no_proto_err", 64'(bus.proto_err), 64'(0));
        check("drain_starved_clr",  64'(bus.starved),   64'(0));

        // Starvation on a buffered head flit.
        drive(1'b1, 1'b1, 1'b1, 32'h33, 1'b1);
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("starve_wait0", 64'(bus.wait_count), 64'(0));
        for (int i = 1; i <= 6; i++) begin
            next();
            check("starve_wait",    64'(bus.wait_count), 64'(i));
            check("starve_starved", 64'(bus.starved),    64'(i >= 5));
        end
        gnt = 1'b1;
        next();
        gnt = 1'b0;
        check("starve_wait_clr",  64'(bus.wait_count), 64'(0));
        check("starve_lag",       64'(bus.starved),    64'(1));
        check("starve_out_valid", 64'(bus.out_valid),  64'(1));
        next();
        check("starve_clr",       64'(bus.starved),    64'(0));

        // Mid-packet bubble.
        tie = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b1);
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        next();
        check("bub_head_out", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("bub_req",  64'(bus.req),        64'(0));
            check("bub_wait", 64'(bus.wait_count), 64'(0));
            next();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h41, 1'b1);
        next();
        drive(1'b1, 1'b0, 1'b1, 32'h42, 1'b1);
        check("bub_body_req", 64'(bus.req), 64'(1));
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("bub_tail_req", 64'(bus.req), 64'(1));
        next();
        check("bub_done_req",  64'(bus.req),      64'(0));
        check("bub_done_tail", 64'(bus.out_tail), 64'(1));
        next();
        check("bub_idle_valid", 64'(bus.out_valid), 64'(0));

        // Stray body flit in IDLE is dropped.
        drive(1'b1, 1'b0, 1'b0, 32'h50, 1'b0);
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("drop_req",   64'(bus.req),       64'(0));
        check("drop_perr0", 64'(bus.proto_err), 64'(0));
        next();
        check("drop_perr1", 64'(bus.proto_err), 64'(1));
        check("drop_valid", 64'(bus.out_valid), 64'(0));
        next();
        check("drop_perr2",    64'(bus.proto_err), 64'(0));
        check("drop_in_ready", 64'(bus.in_ready),  64'(1));

        // Spurious grant.
        tie = 1'b0;
        gnt = 1'b1;
        next();
        gnt = 1'b0;
        check("spur_perr",     64'(bus.proto_err), 64'(1));
        check("spur_req",      64'(bus.req),       64'(0));
        check("spur_in_ready", 64'(bus.in_ready),  64'(1));
        check("spur_valid",    64'(bus.out_valid), 64'(0));
        next();
        check("spur_perr_clr", 64'(bus.proto_err), 64'(0));

        // Asynchronous reset with a packet in flight.
        drive(1'b1, 1'b1, 1'b0, 32'h60, 1'b1);
        next();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        gnt = 1'b1;
        next();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, DATA_WIDTH'(32'h61 + i), 1'b0);
            next();
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("mid_req", 64'(bus.req), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_req",       64'(bus.req),        64'(0));
        check("arst_out_valid", 64'(bus.out_valid),  64'(0));
        check("arst_out_data",  64'(bus.out_data),   64'(0));
        check("arst_out_head",  64'(bus.out_head),   64'(0));
        check("arst_wait",      64'(bus.wait_count), 64'(0));
        check("arst_starved",   64'(bus.starved),    64'(0));
        check("arst_proto_err", 64'(bus.proto_err),  64'(0));
        check("arst_in_ready",  64'(bus.in_ready),   64'(1));
        next();
        #2 rst = 1'b0;
        tie = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            check("post_rst_req",      64'(bus.req),       64'(0));
            check("post_rst_valid",    64'(bus.out_valid), 64'(0));
            check("post_rst_in_ready", 64'(bus.in_ready),  64'(1));
        end

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
